// File: rtl/sar_conv_host.sv
// Host-side sequencer for a SAR converter: drives the active-low start handshake,
// captures results into a first-word-fall-through FIFO, and flags lost data and hung conversions.
module sar_conv_host #(
  parameter int DATA_W     = 5,
  parameter int PERIOD_W   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 63
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [PERIOD_W-1:0]         period,
  output logic                        nStartCnv,
  input  logic                        nEndCnv,
  input  logic [DATA_W-1:0]           adcData,
  input  logic                        rdEn,
  output logic [DATA_W-1:0]           rdData,
  output logic                        fifoEmpty,
  output logic                        fifoFull,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overrun,
  output logic                        timeoutErr,
  input  logic                        clrErr,
  output logic                        busy
);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  // Last wait value before the counter would reach TIMEOUT: a state lasts at most TIMEOUT cycles.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W + 1){1'b0}};

  typedef enum logic [1:0] {S_IDLE, S_START, S_CONV, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [PERIOD_W-1:0] gap_q, gap_d;
  logic                nstart_q, busy_q;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic                empty_q, full_q, ovr_q, ovr_d, tmo_q, tmo_d;
  logic                capture_s, tmo_s, push_s, pop_s, drop_s;

  // Sequencer next state: handshake progress, wait timeout and inter-conversion gap.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    gap_d     = gap_q;
    capture_s = 1'b0;
    tmo_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A SAR still busy after a timeout must finish before it is restarted.
        if (enable && !nEndCnv) begin
          state_d = S_START;
          wait_d  = {WAIT_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (nEndCnv) begin
          state_d = S_CONV;
          wait_d  = {WAIT_W{1'b0}};
        end else if (wait_q == WAIT_LAST) begin
          tmo_s   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_CONV: begin
        if (!nEndCnv) begin
          capture_s = 1'b1;
          state_d   = S_GAP;
          gap_d     = period;
        end else if (wait_q == WAIT_LAST) begin
          tmo_s   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q != {PERIOD_W{1'b0}}) begin
          gap_d = gap_q - PERIOD_W'(1);
        end else if (enable) begin
          state_d = S_START;
          wait_d  = {WAIT_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointer arithmetic and sticky error flags; a pop while full frees room for the capture.
  always_comb begin
    pop_s    = rdEn && !empty_q;
    push_s   = capture_s && (!full_q || pop_s);
    drop_s   = capture_s && !push_s;
    wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, push_s};
    rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, pop_s};
    count_d  = wr_ptr_d - rd_ptr_d;
    ovr_d    = (ovr_q && !clrErr) || drop_s;
    tmo_d    = (tmo_q && !clrErr) || tmo_s;
  end

  // State, handshake output and status registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wait_q   <= {WAIT_W{1'b0}};
      gap_q    <= {PERIOD_W{1'b0}};
      nstart_q <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= CNT_ZERO;
      rd_ptr_q <= CNT_ZERO;
      count_q  <= CNT_ZERO;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovr_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      gap_q    <= gap_d;
      nstart_q <= (state_d != S_START);
      busy_q   <= (state_d != S_IDLE);
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == CNT_ZERO);
      full_q   <= (count_d == CNT_FULL);
      ovr_q    <= ovr_d;
      tmo_q    <= tmo_d;
    end
  end

  // Result storage, cleared on reset so the head reads zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= adcData;
    end else begin
      mem_q <= mem_q;
    end
  end

  assign nStartCnv  = nstart_q;
  assign busy       = busy_q;
  assign rdData     = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign fifoEmpty  = empty_q;
  assign fifoFull   = full_q;
  assign count      = count_q;
  assign overrun    = ovr_q;
  assign timeoutErr = tmo_q;
endmodule

// File: tb/tb_sar_conv_host.sv
// Self-checking bench for sar_conv_host: a behavioural SAR converter drives the handshake and a
// queue-based FIFO model predicts occupancy, head data and the overrun flag every cycle.
module tb_sar_conv_host;
  localparam int BUSY        = 20;
  // START lasts 3 cycles against this SAR, CONV lasts BUSY cycles, GAP one cycle at period 0.
  localparam int EXP_SPACING = 3 + BUSY + 1;

  logic       clock = 1'b0;
  logic       reset, enable, nEndCnv, rdEn, clrErr;
  logic [7:0] period;
  logic [4:0] adcData;
  logic       nStartCnv, fifoEmpty, fifoFull, overrun, timeoutErr, busy;
  logic [4:0] rdData;
  logic [2:0] count;

  always #5 clock = ~clock;

  sar_conv_host dut (
    .clock(clock), .reset(reset), .enable(enable), .period(period),
    .nStartCnv(nStartCnv), .nEndCnv(nEndCnv), .adcData(adcData),
    .rdEn(rdEn), .rdData(rdData), .fifoEmpty(fifoEmpty), .fifoFull(fifoFull),
    .count(count), .overrun(overrun), .timeoutErr(timeoutErr), .clrErr(clrErr), .busy(busy)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [4:0] mq[$];
  logic       m_ovr = 1'b0;
  int         m_caps = 0;
  logic       cap_pending = 1'b0;
  logic [4:0] cap_code = 5'd0;
  logic [4:0] code_q[$];
  int         sar_mode = 0;   // 0 normal, 1 never acknowledges, 2 acknowledges but never finishes
  int         sar_phase = 0;
  int         sar_cnt = 0;
  int         cyc = 0;
  int         st_q[$];
  logic       prev_ns = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: apply model effects of the rising edge, then check and step the SAR on the falling edge.
  task automatic cycle();
    int was;
    bit do_pop, do_push;
    @(posedge clock);
    cyc++;
    if (reset) begin
      was     = mq.size();
      do_pop  = rdEn && (was > 0);
      do_push = cap_pending && ((was < 4) || do_pop);
      if (clrErr) m_ovr = 1'b0;
      if (cap_pending && !do_push) m_ovr = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(cap_code);
      if (cap_pending) m_caps++;
    end
    cap_pending = 1'b0;
    @(negedge clock);
    check_val("count", 32'(count), 32'(mq.size()));
    check_val("empty", 32'(fifoEmpty), 32'(mq.size() == 0));
    check_val("full", 32'(fifoFull), 32'(mq.size() == 4));
    check_val("overrun", 32'(overrun), 32'(m_ovr));
    if (mq.size() > 0) check_val("rd_data", 32'(rdData), 32'(mq[0]));
    if (prev_ns && !nStartCnv) st_q.push_back(cyc);
    prev_ns = nStartCnv;
    if (!reset) begin
      nEndCnv   = 1'b0;
      sar_phase = 0;
    end else if (sar_mode != 1) begin
      if (sar_phase == 0) begin
        if (!nStartCnv && !nEndCnv) sar_phase = 1;
      end else if (sar_phase == 1) begin
        sar_phase = 2;
      end else if (sar_phase == 2) begin
        nEndCnv   = 1'b1;
        sar_cnt   = BUSY;
        sar_phase = 3;
      end else if (sar_mode == 0) begin
        sar_cnt--;
        if (sar_cnt == 0) begin
          adcData     = (code_q.size() > 0) ? code_q.pop_front() : 5'($urandom_range(0, 31));
          cap_code    = adcData;
          nEndCnv     = 1'b0;
          cap_pending = 1'b1;
          sar_phase   = 0;
        end
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_caps(input int target, input string tag);
    int n = 0;
    while (m_caps < target && n < 500) begin cycle(); n++; end
    check_val(tag, 32'(m_caps >= target), 32'd1);
  endtask

  task automatic wait_pending(input string tag);
    int n = 0;
    while (!cap_pending && n < 200) begin cycle(); n++; end
    check_val(tag, 32'(cap_pending), 32'd1);
  endtask

  task automatic wait_conv(input string tag);
    int n = 0;
    while (sar_phase != 3 && n < 200) begin cycle(); n++; end
    check_val(tag, 32'(sar_phase), 32'd3);
  endtask

  task automatic pop_n(input int n);
    repeat (n) begin rdEn = 1'b1; cycle(); end
    rdEn = 1'b0;
  endtask

  task automatic pulse_clr();
    clrErr = 1'b1; cycle(); clrErr = 1'b0;
  endtask

  task automatic check_spacing(input string tag, input int exp);
    for (int i = 1; i < st_q.size(); i++) check_val(tag, 32'(st_q[i] - st_q[i-1]), 32'(exp));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         c0, n, lowc;
    logic [4:0] first_code;
    logic [4:0] exp_codes[4];
    exp_codes = '{5'd3, 5'd17, 5'd30, 5'd0};
    reset = 1'b0; enable = 1'b0; period = 8'd0; nEndCnv = 1'b0;
    rdEn = 1'b0; clrErr = 1'b0; adcData = 5'd0;
    run(3);
    check_val("rst_nstart", 32'(nStartCnv), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_rddata", 32'(rdData), 32'd0);
    check_val("rst_tmo", 32'(timeoutErr), 32'd0);
    reset = 1'b1;
    run(2);

    // Single conversion of code 19 from a one-cycle enable pulse.
    code_q.push_back(5'd19);
    st_q.delete();
    enable = 1'b1; cycle(); enable = 1'b0;
    run(40);
    check_val("single_starts", 32'(st_q.size()), 32'd1);
    check_val("single_count", 32'(count), 32'd1);
    check_val("single_data", 32'(rdData), 32'd19);
    pop_n(1);
    check_val("single_empty", 32'(fifoEmpty), 32'd1);

    // Back-to-back throughput at period 0.
    st_q.delete(); c0 = m_caps; period = 8'd0; enable = 1'b1;
    wait_caps(c0 + 3, "thru_caps");
    enable = 1'b0;
    run(5);
    check_val("thru_starts", 32'(st_q.size()), 32'd3);
    check_spacing("thru_spacing", EXP_SPACING);
    pop_n(3);

    // Continuous conversion with period 10.
    foreach (exp_codes[i]) code_q.push_back(exp_codes[i]);
    st_q.delete(); c0 = m_caps; period = 8'd10; enable = 1'b1;
    wait_caps(c0 + 4, "cont_caps");
    enable = 1'b0;
    run(15);
    check_val("cont_starts", 32'(st_q.size()), 32'd4);
    check_spacing("cont_spacing", EXP_SPACING + 10);
    for (int i = 0; i < 4; i++) begin
      check_val("cont_res", 32'(rdData), 32'(exp_codes[i]));
      pop_n(1);
    end

    // Overrun: five results, no reads.
    period = 8'd0;
    first_code = 5'($urandom_range(0, 31));
    code_q.push_back(first_code);
    repeat (4) code_q.push_back(5'($urandom_range(0, 31)));
    c0 = m_caps; enable = 1'b1;
    wait_caps(c0 + 5, "ovr_caps");
    enable = 1'b0;
    run(3);
    check_val("ovr_full", 32'(fifoFull), 32'd1);
    check_val("ovr_count", 32'(count), 32'd4);
    check_val("ovr_flag", 32'(overrun), 32'd1);
    check_val("ovr_head", 32'(rdData), 32'(first_code));
    pulse_clr();
    check_val("ovr_clr", 32'(overrun), 32'd0);

    // Pop on every capture edge while full; order survives pointer wrap.
    repeat (6) code_q.push_back(5'($urandom_range(0, 31)));
    enable = 1'b1;
    repeat (6) begin
      wait_pending("rw_pending");
      rdEn = 1'b1; cycle(); rdEn = 1'b0;
      check_val("rw_count", 32'(count), 32'd4);
      check_val("rw_ovr", 32'(overrun), 32'd0);
    end
    enable = 1'b0;
    run(3);
    pop_n(4);
    check_val("rw_drained", 32'(fifoEmpty), 32'd1);

    // Randomized traffic: enable, period, reads and clears all vary.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      if ($urandom_range(0, 49) == 0) period = 8'($urandom_range(0, 4));
      rdEn   = ($urandom_range(0, 3) == 0);
      clrErr = ($urandom_range(0, 15) == 0);
      cycle();
    end
    enable = 1'b0; rdEn = 1'b0; clrErr = 1'b0;
    n = 0;
    while ((busy || nEndCnv || cap_pending) && n < 200) begin cycle(); n++; end
    check_val("rand_settle", 32'(busy), 32'd0);
    pop_n(4);
    pulse_clr();

    // Start timeout: the SAR never acknowledges.
    check_val("tmo_pre", 32'(timeoutErr), 32'd0);
    sar_mode = 1; st_q.delete(); lowc = 0;
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cycle();
      enable = 1'b0;
      if (!nStartCnv) lowc++;
    end
    check_val("start_tmo_len", 32'(lowc), 32'd63);
    check_val("start_tmo_flag", 32'(timeoutErr), 32'd1);
    check_val("start_tmo_nstart", 32'(nStartCnv), 32'd1);
    check_val("start_tmo_busy", 32'(busy), 32'd0);
    check_val("start_tmo_starts", 32'(st_q.size()), 32'd1);
    pulse_clr();
    check_val("tmo_clr", 32'(timeoutErr), 32'd0);

    // Conversion timeout: the SAR stays busy; no restart until it releases.
    sar_mode = 2; st_q.delete(); n = 0;
    enable = 1'b1;
    while (!timeoutErr && n < 300) begin cycle(); n++; end
    check_val("conv_tmo_len", 32'(n), 32'd67);
    check_val("conv_tmo_nstart", 32'(nStartCnv), 32'd1);
    check_val("conv_tmo_busy", 32'(busy), 32'd0);
    run(20);
    check_val("conv_tmo_hold", 32'(st_q.size()), 32'd1);
    check_val("conv_tmo_idle", 32'(busy), 32'd0);
    sar_mode = 0; sar_phase = 0; nEndCnv = 1'b0; c0 = m_caps;
    wait_caps(c0 + 1, "conv_tmo_resume");
    enable = 1'b0;
    run(3);
    check_val("conv_tmo_restart", 32'(st_q.size()), 32'd2);
    pulse_clr();

    // Enable dropped mid-CONV: the result is still captured, then IDLE.
    st_q.delete(); c0 = m_caps; enable = 1'b1;
    wait_conv("endrop_conv");
    run(5);
    enable = 1'b0;
    wait_caps(c0 + 1, "endrop_cap");
    run(5);
    check_val("endrop_busy", 32'(busy), 32'd0);
    check_val("endrop_starts", 32'(st_q.size()), 32'd1);

    // Reset asserted mid-CONV with data in the FIFO.
    enable = 1'b1;
    wait_conv("rst_conv");
    run(3);
    check_val("rst_pre_count", 32'(count != 3'd0), 32'd1);
    reset = 1'b0;
    #1;
    check_val("mrst_nstart", 32'(nStartCnv), 32'd1);
    check_val("mrst_busy", 32'(busy), 32'd0);
    check_val("mrst_empty", 32'(fifoEmpty), 32'd1);
    check_val("mrst_full", 32'(fifoFull), 32'd0);
    check_val("mrst_count", 32'(count), 32'd0);
    check_val("mrst_rddata", 32'(rdData), 32'd0);
    check_val("mrst_ovr", 32'(overrun), 32'd0);
    check_val("mrst_tmo", 32'(timeoutErr), 32'd0);
    mq.delete(); m_ovr = 1'b0; cap_pending = 1'b0;
    nEndCnv = 1'b0; sar_phase = 0; enable = 1'b0; prev_ns = 1'b1;
    run(2);
    reset = 1'b1;
    run(3);
    check_val("post_rst_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
